// File: rtl/dff_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dff_arb_pkg
// Description : Shared types, state constants and the wrapping first-set-bit
//               search used by the register-bank arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dff_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle    = 2'd0;
    localparam state_t c_st_grant   = 2'd1;
    localparam state_t c_st_release = 2'd2;

    // Largest requester count any arbiter built on these helpers supports.
    localparam int unsigned c_max_req   = 8;
    localparam int unsigned c_max_idx_w = 3;

    typedef struct packed {
        logic                   found;
        logic [c_max_idx_w-1:0] idx;
    } pick_t;

    // The hold counter must be able to count from 0 up to max_hold.
    function automatic int unsigned hold_cnt_width(input int unsigned max_hold);
        return $clog2(max_hold + 1);
    endfunction

    // First set bit of req[nreq-1:0], scanning ptr, ptr+1, ... modulo nreq.
    function automatic pick_t rr_first_set(
        input logic [c_max_req-1:0]   req,
        input logic [c_max_idx_w-1:0] ptr,
        input int unsigned            nreq
    );
        pick_t       r;
        int unsigned k;
        r = '0;
        for (int unsigned i = 0; i < c_max_req; i++) begin
            if (i < nreq && !r.found) begin
                k = (32'(ptr) + i) % nreq;
                if (req[k[c_max_idx_w-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = k[c_max_idx_w-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff_bank_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector: one-hot winner and index
//               of the first active request at or after the priority pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import dff_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [c_max_req-1:0]   w_req_pad;
    logic [c_max_idx_w-1:0] w_ptr_pad;
    pick_t                  w_pick;

    always_comb begin
        w_req_pad              = '0;
        w_req_pad[NREQ-1:0]    = i_req;
        w_ptr_pad              = '0;
        w_ptr_pad[IDX_W-1:0]   = i_ptr;
        w_pick                 = rr_first_set(w_req_pad, w_ptr_pad, NREQ);
    end

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick.found && (w_pick.idx == c_max_idx_w'(i))) begin
                o_onehot[i] = 1'b1;
                o_idx       = IDX_W'(i);
            end
        end
    end

    assign o_valid = w_pick.found;

endmodule
`default_nettype wire

// File: rtl/dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dff_bank_arbiter
// Description : Round-robin arbiter and bounded-burst write sequencer for a
//               shared WIDTH-bit register bank with q and complementary qb.
//               Optional parity tracking: define DFF_ARB_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_bank_arbiter
    import dff_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef DFF_ARB_PARITY_EN
    input  logic [NREQ-1:0]       wpar,
    output logic                  q_par,
    output logic                  par_err,
`endif
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic [WIDTH-1:0]      qb,
    output logic                  wr_valid,
    output logic                  busy
);

    localparam int unsigned c_idx_w  = $clog2(NREQ);
    localparam int unsigned c_hold_w = hold_cnt_width(MAX_HOLD);

    state_t                state_q,    state_d;
    logic [c_idx_w-1:0]    ptr_q,      ptr_d;
    logic [c_idx_w-1:0]    g_idx_q,    g_idx_d;
    logic [c_hold_w-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NREQ-1:0]       gnt_q,      gnt_d;
    logic [WIDTH-1:0]      bank_q,     bank_d;
    logic [WIDTH-1:0]      bank_b_q,   bank_b_d;
    logic                  wr_valid_q, wr_valid_d;

    logic [NREQ-1:0]       w_pick_onehot;
    logic [c_idx_w-1:0]    w_pick_idx;
    logic                  w_pick_valid;
    logic [WIDTH-1:0]      w_wr_data;
    logic                  w_req_g;
    logic                  w_write;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (c_idx_w)
    ) u_rr_pick (
        .i_req    (req),
        .i_ptr    (ptr_q),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    // Only the granted slice is selected, so X on other slices never leaks in.
    always_comb begin
        w_wr_data = '0;
        w_req_g   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (g_idx_q == c_idx_w'(i)) begin
                w_wr_data = wdata[i*WIDTH +: WIDTH];
                w_req_g   = req[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        g_idx_d    = g_idx_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        bank_d     = bank_q;
        bank_b_d   = bank_b_q;
        wr_valid_d = 1'b0;
        w_write    = 1'b0;
        case (state_q)
            c_st_idle: begin
                if (w_pick_valid) begin
                    state_d    = c_st_grant;
                    gnt_d      = w_pick_onehot;
                    g_idx_d    = w_pick_idx;
                    hold_cnt_d = '0;
                end
            end
            c_st_grant: begin
                if (w_req_g) begin
                    w_write    = 1'b1;
                    bank_d     = w_wr_data;
                    bank_b_d   = ~w_wr_data;
                    wr_valid_d = 1'b1;
                    hold_cnt_d = hold_cnt_q + c_hold_w'(1);
                    // Last permitted write of the burst still lands.
                    if (hold_cnt_q == c_hold_w'(MAX_HOLD - 1)) begin
                        state_d = c_st_release;
                        gnt_d   = '0;
                    end
                end else begin
                    state_d = c_st_release;
                    gnt_d   = '0;
                end
            end
            c_st_release: begin
                ptr_d   = (g_idx_q == c_idx_w'(NREQ - 1)) ? '0 : g_idx_q + c_idx_w'(1);
                state_d = c_st_idle;
            end
            default: begin
                state_d = c_st_idle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_st_idle;
            ptr_q      <= '0;
            g_idx_q    <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            bank_q     <= '0;
            bank_b_q   <= '1;
            wr_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            g_idx_q    <= g_idx_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            bank_q     <= bank_d;
            bank_b_q   <= bank_b_d;
            wr_valid_q <= wr_valid_d;
        end
    end

    assign gnt      = gnt_q;
    assign q        = bank_q;
    assign qb       = bank_b_q;
    assign wr_valid = wr_valid_q;
    assign busy     = (state_q != c_st_idle);

`ifdef DFF_ARB_PARITY_EN
    logic q_par_q,   q_par_d;
    logic par_err_q, par_err_d;
    logic w_par_g;

    always_comb begin
        w_par_g = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (g_idx_q == c_idx_w'(i)) begin
                w_par_g = wpar[i];
            end
        end
    end

    // A parity mismatch is still written; only the sticky flag records it.
    always_comb begin
        q_par_d   = q_par_q;
        par_err_d = par_err_q;
        if (w_write) begin
            q_par_d = ^w_wr_data;
            if ((^w_wr_data) != w_par_g) begin
                par_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_par_q   <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            q_par_q   <= q_par_d;
            par_err_q <= par_err_d;
        end
    end

    assign q_par   = q_par_q;
    assign par_err = par_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_bank_arbiter
// Description : Self-checking bench for dff_bank_arbiter: directed scenarios
//               plus randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_bank_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] wdata = '0;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      qb;
    logic                  wr_valid;
    logic                  busy;
`ifdef DFF_ARB_PARITY_EN
    logic [NREQ-1:0]       wpar = '0;
    logic                  q_par;
    logic                  par_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: phase 0 = nobody owns the bank, 1 = owner writing,
    // 2 = mandatory cool-down cycle after a burst.
    int              m_phase  = 0;
    int              m_ptr    = 0;
    int              m_owner  = 0;
    int              m_writes = 0;
    logic [WIDTH-1:0] m_q     = '0;
    logic [NREQ-1:0]  m_gnt   = '0;
    logic             m_wv    = 1'b0;

    dff_bank_arbiter #(
        .NREQ     (NREQ),
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wdata    (wdata),
`ifdef DFF_ARB_PARITY_EN
        .wpar     (wpar),
        .q_par    (q_par),
        .par_err  (par_err),
`endif
        .gnt      (gnt),
        .q        (q),
        .qb       (qb),
        .wr_valid (wr_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        int k;
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_owner = 0; m_writes = 0;
            m_q = '0; m_gnt = '0; m_wv = 1'b0;
        end else begin
            m_wv = 1'b0;
            case (m_phase)
                0: begin
                    for (int off = 0; off < NREQ; off++) begin
                        k = (m_ptr + off) % NREQ;
                        if (m_phase == 0 && req[k]) begin
                            m_owner  = k;
                            m_writes = 0;
                            m_phase  = 1;
                            m_gnt    = '0;
                            m_gnt[k] = 1'b1;
                        end
                    end
                end
                1: begin
                    if (req[m_owner]) begin
                        m_q = wdata[m_owner*WIDTH +: WIDTH];
                        m_wv = 1'b1;
                        m_writes++;
                        if (m_writes == MAX_HOLD) begin
                            m_phase = 2;
                            m_gnt   = '0;
                        end
                    end else begin
                        m_phase = 2;
                        m_gnt   = '0;
                    end
                end
                default: begin
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_phase = 0;
                end
            endcase
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        req = '0;
        n = 0;
        step();
        while (busy && n < 12) begin
            step();
            n++;
        end
        n_checks++; if (busy !== 1'b0) $display("FAIL drain_timeout: busy=%b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        wdata = $urandom();
        step();
        step();
        n_checks++; if (q !== 8'h00) $display("FAIL reset_q: got %h want 00", q); else n_pass++;
        n_checks++; if (qb !== 8'hFF) $display("FAIL reset_qb: got %h want ff", qb); else n_pass++;
        n_checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (wr_valid !== 1'b0) $display("FAIL reset_wr_valid: got %b want 0", wr_valid); else n_pass++;
        rst = 1'b0;
        req = '0;
        step();
    endtask

    task automatic test_single();
        req = 4'b0100;
        wdata = $urandom();
        wdata[2*WIDTH +: WIDTH] = 8'hA5;
        step();
        n_checks++; if (gnt !== 4'b0100) $display("FAIL single_gnt: got %b want 0100", gnt); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
        n_checks++; if (wr_valid !== 1'b0) $display("FAIL single_no_early_write: got %b want 0", wr_valid); else n_pass++;
        step();
        n_checks++; if (q !== 8'hA5 || qb !== 8'h5A || wr_valid !== 1'b1)
            $display("FAIL single_write1: q=%h qb=%h wv=%b want a5 5a 1", q, qb, wr_valid); else n_pass++;
        wdata[2*WIDTH +: WIDTH] = 8'h3C;
        step();
        n_checks++; if (q !== 8'h3C || qb !== 8'hC3 || wr_valid !== 1'b1)
            $display("FAIL single_write2: q=%h qb=%h wv=%b want 3c c3 1", q, qb, wr_valid); else n_pass++;
        req = '0;
        step();
        n_checks++; if (gnt !== 4'b0000 || busy !== 1'b1 || wr_valid !== 1'b0 || q !== 8'h3C)
            $display("FAIL single_release: gnt=%b busy=%b wv=%b q=%h want 0000 1 0 3c", gnt, busy, wr_valid, q); else n_pass++;
        step();
        n_checks++; if (busy !== 1'b0) $display("FAIL single_idle: busy=%b want 0", busy); else n_pass++;
        // Pointer should now sit at 3, so requester 3 beats requester 0.
        req = 4'b1001;
        step();
        n_checks++; if (gnt !== 4'b1000) $display("FAIL single_ptr3: gnt=%b want 1000", gnt); else n_pass++;
        drain();
    endtask

    task automatic test_hold_limit();
        int writes;
        writes = 0;
        req = 4'b0001;
        for (int s = 1; s <= 10; s++) begin
            wdata = $urandom();
            step();
            if (s <= 6 && wr_valid === 1'b1) writes++;
            if (s == 5) begin
                n_checks++; if (gnt !== 4'b0000 || busy !== 1'b1)
                    $display("FAIL hold_release: gnt=%b busy=%b want 0000 1", gnt, busy); else n_pass++;
            end
            if (s == 6) begin
                n_checks++; if (busy !== 1'b0) $display("FAIL hold_idle: busy=%b want 0", busy); else n_pass++;
            end
            if (s == 7) begin
                n_checks++; if (gnt !== 4'b0001) $display("FAIL hold_regrant: gnt=%b want 0001", gnt); else n_pass++;
            end
        end
        n_checks++; if (writes != MAX_HOLD) $display("FAIL hold_count: got %0d writes want %0d", writes, MAX_HOLD); else n_pass++;
        drain();
    endtask

    task automatic test_rotation();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int waited;
        int idx;
        logic [WIDTH-1:0] expd;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        wdata = $urandom();
        for (int n = 0; n < 5; n++) begin
            waited = 0;
            while (gnt == '0 && waited < 20) begin
                step();
                waited++;
            end
            idx = -1;
            for (int i = 0; i < NREQ; i++) if (gnt[i]) idx = i;
            n_checks++; if (idx != exp_order[n] || !$onehot(gnt))
                $display("FAIL rotation_order%0d: gnt=%b want requester %0d", n, gnt, exp_order[n]); else n_pass++;
            if (idx < 0) idx = 0;
            expd = wdata[idx*WIDTH +: WIDTH];
            step();
            n_checks++; if (wr_valid !== 1'b1 || q !== expd)
                $display("FAIL rotation_write%0d: wv=%b q=%h want 1 %h", n, wr_valid, q, expd); else n_pass++;
            req[idx] = 1'b0;
            step();
            n_checks++; if (gnt !== 4'b0000 || busy !== 1'b1)
                $display("FAIL rotation_release%0d: gnt=%b busy=%b want 0000 1", n, gnt, busy); else n_pass++;
            req[idx] = 1'b1;
            wdata = $urandom();
            step();
            n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0)
                $display("FAIL rotation_idle%0d: gnt=%b busy=%b want 0000 0", n, gnt, busy); else n_pass++;
        end
        req = '0;
        step();
        drain();
    endtask

    task automatic test_mid_reset();
        req = 4'b0010;
        wdata = $urandom();
        step();
        n_checks++; if (gnt !== 4'b0010) $display("FAIL midrst_gnt: gnt=%b want 0010", gnt); else n_pass++;
        step();
        rst = 1'b1;
        step();
        n_checks++; if (q !== 8'h00 || qb !== 8'hFF || gnt !== 4'b0000 || busy !== 1'b0 || wr_valid !== 1'b0)
            $display("FAIL midrst_state: q=%h qb=%h gnt=%b busy=%b wv=%b want 00 ff 0000 0 0",
                     q, qb, gnt, busy, wr_valid); else n_pass++;
        rst = 1'b0;
        req = 4'b0110;
        step();
        n_checks++; if (gnt !== 4'b0010) $display("FAIL midrst_regrant: gnt=%b want 0010", gnt); else n_pass++;
        drain();
    endtask

`ifdef DFF_ARB_PARITY_EN
    task automatic test_parity();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b0001;
        wdata = '0;
        wdata[WIDTH-1:0] = 8'h07;
        wpar = 4'b0000;
        step();
        step();
        n_checks++; if (q_par !== 1'b1 || par_err !== 1'b1 || q !== 8'h07)
            $display("FAIL parity_bad: q=%h q_par=%b par_err=%b want 07 1 1", q, q_par, par_err); else n_pass++;
        wdata[WIDTH-1:0] = 8'h03;
        step();
        n_checks++; if (q_par !== 1'b0 || par_err !== 1'b1 || q !== 8'h03)
            $display("FAIL parity_sticky: q=%h q_par=%b par_err=%b want 03 0 1", q, q_par, par_err); else n_pass++;
        req = '0;
        rst = 1'b1;
        step();
        n_checks++; if (q_par !== 1'b0 || par_err !== 1'b0)
            $display("FAIL parity_reset: q_par=%b par_err=%b want 0 0", q_par, par_err); else n_pass++;
        rst = 1'b0;
        step();
    endtask
`endif

    task automatic test_random();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(3) == 0) req = NREQ'($urandom());
            wdata = $urandom();
            rst = ($urandom_range(49) == 0);
`ifdef DFF_ARB_PARITY_EN
            for (int i = 0; i < NREQ; i++) wpar[i] = ^wdata[i*WIDTH +: WIDTH];
`endif
            step();
            n_checks++; if (gnt !== m_gnt) $display("FAIL rand_gnt c%0d: got %b want %b", c, gnt, m_gnt); else n_pass++;
            n_checks++; if (q !== m_q) $display("FAIL rand_q c%0d: got %h want %h", c, q, m_q); else n_pass++;
            n_checks++; if (qb !== ~m_q) $display("FAIL rand_qb c%0d: got %h want %h", c, qb, ~m_q); else n_pass++;
            n_checks++; if (wr_valid !== m_wv) $display("FAIL rand_wv c%0d: got %b want %b", c, wr_valid, m_wv); else n_pass++;
            n_checks++; if (busy !== (m_phase != 0)) $display("FAIL rand_busy c%0d: got %b want %b", c, busy, m_phase != 0); else n_pass++;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold_limit();
        test_rotation();
        test_mid_reset();
`ifdef DFF_ARB_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared WIDTH-bit D-flip-flop register bank with q and complementary qb outputs.
- Up to NREQ requesters compete for write access.
- The winner holds the bank for a bounded burst of writes. The bank then releases and the priority pointer rotates.
- Sits between requesting control blocks and the shared storage register. Only this block may write the bank.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, register bank width in bits.
- MAX_HOLD, 4, maximum writes per grant (1..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset: synchronous, active-high.
- req  input  NREQ  per-requester request, level; bit i is requester i.
- wdata  input  NREQ*WIDTH  write data; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant, registered.
- q  output  WIDTH  bank contents, registered.
- qb  output  WIDTH  complement of q, registered; always equal to ~q.
- wr_valid  output  1  one-cycle pulse, high in the cycle q/qb show newly written data.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst high at a rising edge; overrides everything, including mid-burst):
  - q=0, qb=all ones, gnt=0, wr_valid=0, busy=0.
  - State=IDLE, ptr=0, hold_cnt=0.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req is nonzero, pick the first set bit scanning ptr, ptr+1, ... wrapping modulo NREQ.
  - Next edge: state=GRANT, gnt=onehot(winner), hold_cnt=0.
  - If req is zero, stay in IDLE.
  - Requests arriving in IDLE are not written that cycle.
- GRANT (winner g):
  - Each cycle with req[g]=1: next edge loads q<=wdata[g], qb<=~wdata[g], wr_valid<=1, hold_cnt+1.
  - Each cycle with req[g]=0: no write, wr_valid<=0, next state=RELEASE.
  - Cycle in which hold_cnt==MAX_HOLD-1 and req[g]=1: the write still happens, next state=RELEASE.
  - Other requesters' req and wdata are ignored during GRANT.
- RELEASE (exactly one cycle):
  - gnt already 0 on entry; it is cleared on the edge leaving GRANT.
  - ptr<=(g+1) mod NREQ; next state=IDLE.
  - Guarantees at least one idle cycle between grants.
- Latency:
  - req rises in IDLE at cycle t -> gnt high in cycle t+1.
  - First q update and wr_valid visible in cycle t+2.
- Bank holds its value whenever no write occurs; wr_valid is 0 in those cycles.
- Fairness: with all requesters continuously asserted, grants follow the order ptr, ptr+1, ... Worst-case wait is (NREQ-1)*(MAX_HOLD+2) cycles.
- Data is taken unmodified; no width conversion.
- X on unused wdata slices must not propagate.

Optional Feature:
- Macro DFF_ARB_PARITY_EN.
- When defined:
  - Adds output q_par (1 bit). Registered, updated together with q, equal to even parity (XOR) of the written data; reset value 0.
  - Adds input wpar (NREQ bits). Requester i supplies the parity of its data on bit i.
  - A write whose computed parity differs from wpar[g] is still written, and the sticky output par_err (1 bit, reset 0, cleared only by rst) is set.
- When undefined: no q_par, wpar or par_err ports and no parity logic.

Decomposition:
- Package dff_arb_pkg:
  - state enum (IDLE, GRANT, RELEASE);
  - localparam for the hold counter width, $clog2(MAX_HOLD+1);
  - function for the wrapping first-set-bit search.
- One natural sub-module: rr_pick. Combinational round-robin selector taking req and ptr, returning a one-hot winner and an index; reusable by other arbiters.
- The bank, counter and FSM stay in the top module.

Test Plan:
- Reset: assert rst 2 cycles with req=4'b1111 -> q=8'h00, qb=8'hFF, gnt=0, busy=0, wr_valid=0.
- Single requester: ptr=0, req[2]=1 for 2 cycles in GRANT with wdata[2]=8'hA5 then 8'h3C, then drop.
  - gnt=4'b0100 from cycle t+1.
  - q=A5/qb=5A in t+2, q=3C/qb=C3 in t+3, each with wr_valid=1.
  - Then RELEASE, IDLE, ptr=3.
- Hold limit: req[0] held 10 cycles -> exactly 4 writes. gnt drops after the 4th, followed by a RELEASE cycle; req[0] is then re-granted because no other requester is active.
- Rotation: all req high, each requester drops req after 1 write -> grant order 0,1,2,3,0. Each grant is separated by RELEASE and IDLE cycles.
- Reset mid-burst: rst in the 2nd GRANT cycle of requester 1 -> next cycle q=00, qb=FF, gnt=0, ptr=0. After rst drops with req=4'b0110, requester 1 wins.
- Parity (DFF_ARB_PARITY_EN): write 8'h07 with wpar=0 -> q_par=1, par_err=1. par_err stays set after later correct writes until rst.
